// File: rtl/axi2iob.sv
// ---------------------------------------------------------------------------
// axi2iob -- AXI4 slave to IOb-bus master bridge.
//
// Lets an AXI master reach IOb-native peripherals and memories. Each AXI INCR
// burst is split into single-word IOb accesses. Only one transaction (read or
// write) is in flight at a time; AW and AR are arbitrated round-robin,
// starting with write after reset.
//
// Ports:
//   clk_i, cke_i, rst_i        clock, clock enable (state holds when low),
//                              synchronous active-high reset
//   axi_aw*/axi_ar*            AXI write/read address channels (id, addr,
//                              len, burst, valid/ready)
//   axi_w*                     AXI write data channel
//   axi_b*                     AXI write response channel
//   axi_r*                     AXI read data channel
//   iob_avalid_o, iob_addr_o,
//   iob_wdata_o, iob_wstrb_o   IOb request (wstrb == 0 means read)
//   iob_rdata_i, iob_rvalid_i,
//   iob_ready_i                IOb response
//
// Build option:
//   AXI2IOB_FIXED_BURST_EN     when defined, a FIXED (2'b00) burst keeps the
//                              start address for every beat; otherwise every
//                              burst type is handled as INCR.
// ---------------------------------------------------------------------------
module axi2iob #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 32,
    parameter int STRB_WIDTH   = DATA_WIDTH / 8,
    parameter int AXI_ID_WIDTH = 8
) (
    input  logic                    clk_i,
    input  logic                    cke_i,
    input  logic                    rst_i,

    input  logic [AXI_ID_WIDTH-1:0] axi_awid_i,
    input  logic [ADDR_WIDTH-1:0]   axi_awaddr_i,
    input  logic [7:0]              axi_awlen_i,
    input  logic [1:0]              axi_awburst_i,
    input  logic                    axi_awvalid_i,
    output logic                    axi_awready_o,

    input  logic [AXI_ID_WIDTH-1:0] axi_arid_i,
    input  logic [ADDR_WIDTH-1:0]   axi_araddr_i,
    input  logic [7:0]              axi_arlen_i,
    input  logic [1:0]              axi_arburst_i,
    input  logic                    axi_arvalid_i,
    output logic                    axi_arready_o,

    input  logic [DATA_WIDTH-1:0]   axi_wdata_i,
    input  logic [STRB_WIDTH-1:0]   axi_wstrb_i,
    input  logic                    axi_wlast_i,
    input  logic                    axi_wvalid_i,
    output logic                    axi_wready_o,

    output logic [AXI_ID_WIDTH-1:0] axi_bid_o,
    output logic [1:0]              axi_bresp_o,
    output logic                    axi_bvalid_o,
    input  logic                    axi_bready_i,

    output logic [AXI_ID_WIDTH-1:0] axi_rid_o,
    output logic [DATA_WIDTH-1:0]   axi_rdata_o,
    output logic [1:0]              axi_rresp_o,
    output logic                    axi_rlast_o,
    output logic                    axi_rvalid_o,
    input  logic                    axi_rready_i,

    output logic                    iob_avalid_o,
    output logic [ADDR_WIDTH-1:0]   iob_addr_o,
    output logic [DATA_WIDTH-1:0]   iob_wdata_o,
    output logic [STRB_WIDTH-1:0]   iob_wstrb_o,
    input  logic [DATA_WIDTH-1:0]   iob_rdata_i,
    input  logic                    iob_rvalid_i,
    input  logic                    iob_ready_i
);

    typedef enum logic [2:0] {
        IDLE,
        W_DATA,
        W_RESP,
        R_REQ,
        R_WAIT,
        R_DATA
    } state_t;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    state_t                  state_q;
    state_t                  state_d;

    logic                    grant_r_q;   // 1: most recent grant went to read
    logic [AXI_ID_WIDTH-1:0] id_q;
    logic [ADDR_WIDTH-1:0]   cur_addr_q;
    logic [7:0]              len_q;
    logic [7:0]              beat_cnt_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic [1:0]              bresp_q;

    logic                    aw_grant;
    logic                    ar_grant;
    logic                    w_has_strb;
    logic                    w_hs;
    logic                    w_end;
    logic                    r_hs;
    logic                    beat_last;
    logic [ADDR_WIDTH-1:0]   addr_next;

    // ------------------------------------------------------------------
    // Shared strobes (ungated by cke_i; state only advances when it is high)
    // ------------------------------------------------------------------
    assign aw_grant   = (state_q == IDLE) & axi_awvalid_i & (~axi_arvalid_i | grant_r_q);
    assign ar_grant   = (state_q == IDLE) & axi_arvalid_i & ~aw_grant;
    assign w_has_strb = |axi_wstrb_i;
    // A zero-strobe beat is swallowed locally: IOb would see it as a read.
    assign w_hs       = (state_q == W_DATA) & axi_wvalid_i & (w_has_strb ? iob_ready_i : 1'b1);
    assign beat_last  = (beat_cnt_q == len_q);
    assign w_end      = w_hs & (axi_wlast_i | beat_last);
    assign r_hs       = (state_q == R_DATA) & axi_rready_i;

`ifdef AXI2IOB_FIXED_BURST_EN
    logic [1:0] burst_q;

    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                burst_q <= '0;
            end else if (aw_grant) begin
                burst_q <= axi_awburst_i;
            end else if (ar_grant) begin
                burst_q <= axi_arburst_i;
            end
        end
    end

    assign addr_next = (burst_q == 2'b00) ? cur_addr_q
                                          : cur_addr_q + ADDR_WIDTH'(STRB_WIDTH);
`else
    logic unused_burst;

    assign unused_burst = ^{axi_awburst_i, axi_arburst_i};
    assign addr_next    = cur_addr_q + ADDR_WIDTH'(STRB_WIDTH);
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                state_q <= IDLE;
            end else begin
                state_q <= state_d;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (aw_grant) begin
                    state_d = W_DATA;
                end else if (ar_grant) begin
                    state_d = R_REQ;
                end
            end
            W_DATA: begin
                if (w_end) begin
                    state_d = W_RESP;
                end
            end
            W_RESP: begin
                if (axi_bready_i) begin
                    state_d = IDLE;
                end
            end
            R_REQ: begin
                if (iob_ready_i) begin
                    state_d = R_WAIT;
                end
            end
            R_WAIT: begin
                if (iob_rvalid_i) begin
                    state_d = R_DATA;
                end
            end
            R_DATA: begin
                if (r_hs) begin
                    state_d = beat_last ? IDLE : R_REQ;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (cke_i) begin
            if (rst_i) begin
                grant_r_q  <= 1'b1;   // first contested grant goes to write
                id_q       <= '0;
                cur_addr_q <= '0;
                len_q      <= '0;
                beat_cnt_q <= '0;
                rdata_q    <= '0;
                bresp_q    <= RESP_OKAY;
            end else begin
                if (aw_grant) begin
                    id_q       <= axi_awid_i;
                    cur_addr_q <= axi_awaddr_i;
                    len_q      <= axi_awlen_i;
                    beat_cnt_q <= '0;
                    grant_r_q  <= 1'b0;
                end else if (ar_grant) begin
                    id_q       <= axi_arid_i;
                    cur_addr_q <= axi_araddr_i;
                    len_q      <= axi_arlen_i;
                    beat_cnt_q <= '0;
                    grant_r_q  <= 1'b1;
                end

                if (w_hs) begin
                    cur_addr_q <= addr_next;
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end

                // Early or missing wlast versus the announced length is an error.
                if (w_end) begin
                    bresp_q <= (axi_wlast_i != beat_last) ? RESP_SLVERR : RESP_OKAY;
                end

                if ((state_q == R_WAIT) && iob_rvalid_i) begin
                    rdata_q <= iob_rdata_i;
                end

                if (r_hs && !beat_last) begin
                    cur_addr_q <= addr_next;
                    beat_cnt_q <= beat_cnt_q + 8'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Handshake signals are qualified with cke_i so that no
    // transfer can be signalled in a cycle where the bridge cannot act on it.
    // ------------------------------------------------------------------
    always_comb begin
        axi_awready_o = 1'b0;
        axi_arready_o = 1'b0;
        axi_wready_o  = 1'b0;
        axi_bid_o     = '0;
        axi_bresp_o   = RESP_OKAY;
        axi_bvalid_o  = 1'b0;
        axi_rid_o     = '0;
        axi_rdata_o   = '0;
        axi_rresp_o   = RESP_OKAY;
        axi_rlast_o   = 1'b0;
        axi_rvalid_o  = 1'b0;
        iob_avalid_o  = 1'b0;
        iob_addr_o    = '0;
        iob_wdata_o   = '0;
        iob_wstrb_o   = '0;

        case (state_q)
            IDLE: begin
                axi_awready_o = cke_i & aw_grant;
                axi_arready_o = cke_i & ar_grant;
            end
            W_DATA: begin
                iob_avalid_o = cke_i & axi_wvalid_i & w_has_strb;
                iob_addr_o   = cur_addr_q;
                iob_wdata_o  = axi_wdata_i;
                iob_wstrb_o  = axi_wstrb_i;
                axi_wready_o = cke_i & (w_has_strb ? iob_ready_i : 1'b1);
            end
            W_RESP: begin
                axi_bvalid_o = cke_i;
                axi_bid_o    = id_q;
                axi_bresp_o  = bresp_q;
            end
            R_REQ: begin
                iob_avalid_o = cke_i;
                iob_addr_o   = cur_addr_q;
            end
            R_DATA: begin
                axi_rvalid_o = cke_i;
                axi_rid_o    = id_q;
                axi_rdata_o  = rdata_q;
                axi_rlast_o  = beat_last;
            end
            default: ;
        endcase
    end

endmodule
